regfile_access_ctrl: RTL and testbench

// Multi-cycle execute/writeback sequencer that initiates all traffic to the 8x8 register file.
// - Accepts one instruction per valid/ready handshake.
// - Drives the two read addresses and captures both operands.
// - Computes an ALU result, then writes it back through the file's single write port.
// - Sits between instruction fetch/decode and the register file.

---
 rtl/regfile_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Purpose: execute/writeback sequencer for an 8x8 register file; optional flags via RFC_FLAGS_EN.
// Latency: accept at edge T, operands read at T+1, ALU at T+2, write/done at T+3; 1 instr per 4 cycles.
// Backpressure: instReady_o is high only in IDLE and low under rst; instValid_i is ignored otherwise.
module regfile_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instValid_i,
    output logic              instReady_o,
    input  logic [2:0]        opcode_i,
    input  logic [ADDR_W-1:0] destReg_i,
    input  logic [ADDR_W-1:0] sourceReg1_i,
    input  logic [ADDR_W-1:0] sourceReg2_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [ADDR_W-1:0] rfSrc1_o,
    output logic [ADDR_W-1:0] rfSrc2_o,
    output logic [ADDR_W-1:0] rfDest_o,
    output logic              rfWrite_o,
    output logic [DATA_W-1:0] rfData_o,
    input  logic [DATA_W-1:0] rfData1_i,
    input  logic [DATA_W-1:0] rfData2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              done_o
`ifdef RFC_FLAGS_EN
    ,
    output logic              zeroFlag_o,
    output logic              carryFlag_o
`endif
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_MOVI = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dest_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_res;
    logic              exec_upd;

    assign accept   = instValid_i && instReady_o;
    // NOP keeps the previous result (and flags) untouched
    assign exec_upd = (state_q == ST_EXEC) && (op_q != OP_NOP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fixed four-step walk, only IDLE waits on the handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction fields are frozen at accept so later input changes cannot leak in
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_ADD;
            dest_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            imm_q  <= '0;
        end else if (accept) begin
            op_q   <= opcode_i;
            dest_q <= destReg_i;
            src1_q <= sourceReg1_i;
            src2_q <= sourceReg2_i;
            imm_q  <= imm_i;
        end
    end

    // Operands captured at the end of READ, before any writeback of this instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state_q == ST_READ) begin
            opa_q <= rfData1_i;
            opb_q <= rfData2_i;
        end
    end

    // ALU: all arithmetic wraps at DATA_W bits
    always_comb begin
        alu_res = result_q;
        case (op_q)
            OP_ADD:  alu_res = opa_q + opb_q;
            OP_SUB:  alu_res = opa_q - opb_q;
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_SHL:  alu_res = opa_q << opb_q[2:0];
            OP_MOVI: alu_res = imm_q;
            default: alu_res = result_q;
        endcase
    end

    // Result register, loaded at the end of EXEC and held until the next EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (exec_upd) begin
            result_q <= alu_res;
        end
    end

`ifdef RFC_FLAGS_EN
    logic alu_carry;
    logic zero_q;
    logic carry_q;

    // Carry: ADD wraps iff the sum is below A, SUB borrows iff A<B, SHL reports the last bit out
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: alu_carry = (alu_res < opa_q);
            OP_SUB: alu_carry = (opa_q < opb_q);
            OP_SHL: begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (i == DATA_W - int'(opb_q[2:0])) alu_carry = opa_q[i];
                end
            end
            default: alu_carry = 1'b0;
        endcase
    end

    // Flags update alongside the result
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (exec_upd) begin
            zero_q  <= (alu_res == '0);
            carry_q <= alu_carry;
        end
    end

    assign zeroFlag_o  = zero_q;
    assign carryFlag_o = carry_q;
`endif

    // Handshake and write strobes are gated by rst so a reset in WB aborts cleanly
    assign instReady_o = (state_q == ST_IDLE) && !rst;
    assign rfWrite_o   = (state_q == ST_WB) && (op_q != OP_NOP) && !rst;
    assign done_o      = (state_q == ST_WB) && !rst;
    assign rfSrc1_o    = src1_q;
    assign rfSrc2_o    = src2_q;
    assign rfDest_o    = dest_q;
    assign rfData_o    = result_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Purpose: self-checking bench for regfile_access_ctrl against a cycle-level behavioural model.
// Latency: model tracks cycles since accept; writes/done expected three cycles after the accept edge.
// Backpressure: stimulus holds instValid_i until accepted and scrambles fields once accepted.
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instValid_i;
    logic       instReady_o;
    logic [2:0] opcode_i;
    logic [2:0] destReg_i;
    logic [2:0] sourceReg1_i;
    logic [2:0] sourceReg2_i;
    logic [7:0] imm_i;
    logic [2:0] rfSrc1_o;
    logic [2:0] rfSrc2_o;
    logic [2:0] rfDest_o;
    logic       rfWrite_o;
    logic [7:0] rfData_o;
    logic [7:0] rfData1_i;
    logic [7:0] rfData2_i;
    logic [7:0] result_o;
    logic       done_o;
`ifdef RFC_FLAGS_EN
    logic       zeroFlag_o;
    logic       carryFlag_o;
`endif

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .instValid_i(instValid_i), .instReady_o(instReady_o),
        .opcode_i(opcode_i), .destReg_i(destReg_i), .sourceReg1_i(sourceReg1_i),
        .sourceReg2_i(sourceReg2_i), .imm_i(imm_i), .rfSrc1_o(rfSrc1_o), .rfSrc2_o(rfSrc2_o),
        .rfDest_o(rfDest_o), .rfWrite_o(rfWrite_o), .rfData_o(rfData_o),
        .rfData1_i(rfData1_i), .rfData2_i(rfData2_i), .result_o(result_o), .done_o(done_o)
`ifdef RFC_FLAGS_EN
        , .zeroFlag_o(zeroFlag_o), .carryFlag_o(carryFlag_o)
`endif
    );

    // Register file seen by the DUT
    logic [7:0] rf [8] = '{8'h00, 8'h07, 8'h06, 8'h3C, 8'h11, 8'h5A, 8'hC3, 8'hFF};
    assign rfData1_i = rf[rfSrc1_o];
    assign rfData2_i = rf[rfSrc2_o];
    always @(posedge clk) if (rfWrite_o) rf[rfDest_o] <= rfData_o;

    // Behavioural model state
    logic [7:0] m_rf [8] = '{8'h00, 8'h07, 8'h06, 8'h3C, 8'h11, 8'h5A, 8'hC3, 8'hFF};
    bit         m_busy = 0;
    int         m_ph = 0;
    logic [2:0] m_op, m_d, m_s1, m_s2;
    logic [7:0] m_imm;
    logic [7:0] m_res = 8'h00;
    bit         m_z = 0, m_c = 0;
    bit         acc;
    int         cyc = 0;
    int         acc_cyc[$];
    logic [10:0] wr_log[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Plain-arithmetic ALU reference
    task automatic ref_alu(input logic [2:0] op, input int a, input int b, input int imm);
        int r, c, s;
        r = 0; c = 0;
        case (op)
            3'd0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            3'd1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin s = b % 8; r = (a << s) % 256; c = (s > 0) ? ((a >> (8 - s)) & 1) : 0; end
            3'd6: r = imm;
            default: return;
        endcase
        m_res = r[7:0];
        m_z = (r == 0);
        m_c = (c != 0);
    endtask

    // One clock: compare at negedge, advance the model, return just after the edge
    task automatic tick();
        bit wb;
        @(negedge clk);
        wb = !rst && m_busy && (m_ph == 3);
        chk("ready", instReady_o, !rst && !m_busy);
        chk("write", rfWrite_o, wb && (m_op != 3'd7));
        chk("done", done_o, wb);
        chk("result", result_o, m_res);
        chk("rfData", rfData_o, m_res);
        if (m_busy) begin
            chk("src1", rfSrc1_o, m_s1);
            chk("src2", rfSrc2_o, m_s2);
            chk("dest", rfDest_o, m_d);
        end
`ifdef RFC_FLAGS_EN
        chk("zero", zeroFlag_o, m_z);
        chk("carry", carryFlag_o, m_c);
`endif
        if (rfWrite_o === 1'b1) wr_log.push_back({rfDest_o, rfData_o});
        acc = 0;
        if (rst) begin
            m_busy = 0; m_res = 8'h00; m_z = 0; m_c = 0;
        end else if (m_busy) begin
            if (m_ph == 2) ref_alu(m_op, int'(m_rf[m_s1]), int'(m_rf[m_s2]), int'(m_imm));
            if (m_ph == 3) begin
                if (m_op != 3'd7) m_rf[m_d] = m_res;
                m_busy = 0;
            end
            m_ph++;
        end else if (instValid_i) begin
            m_op = opcode_i; m_d = destReg_i; m_s1 = sourceReg1_i; m_s2 = sourceReg2_i;
            m_imm = imm_i; m_busy = 1; m_ph = 1; acc = 1;
            acc_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!acc && k < 20);
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] imm);
        opcode_i = op; destReg_i = d; sourceReg1_i = s1; sourceReg2_i = s2; imm_i = imm;
        instValid_i = 1'b1;
        wait_acc();
        instValid_i = 1'b0;
        opcode_i = 3'($urandom); destReg_i = 3'($urandom);
        sourceReg1_i = 3'($urandom); sourceReg2_i = 3'($urandom); imm_i = 8'($urandom);
    endtask

    initial begin
        int n0;
        rst = 1'b1; instValid_i = 1'b0; opcode_i = '0; destReg_i = '0;
        sourceReg1_i = '0; sourceReg2_i = '0; imm_i = '0;

        // Reset held for two cycles
        @(posedge clk); #1;
        tick();
        chk("rst_ready", instReady_o, 1'b0);
        chk("rst_write", rfWrite_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_result", result_o, 8'h00);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", instReady_o, 1'b1);

        // ADD r3 <= r1 + r2 = 0x07 + 0x06
        issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        chk("add_ready_read", instReady_o, 1'b0);
        tick();
        chk("add_ready_exec", instReady_o, 1'b0);
        chk("add_nowrite_exec", rfWrite_o, 1'b0);
        tick();
        chk("add_write", rfWrite_o, 1'b1);
        chk("add_dest", rfDest_o, 3'd3);
        chk("add_data", rfData_o, 8'h0D);
        chk("add_done", done_o, 1'b1);
        chk("add_ready_wb", instReady_o, 1'b0);
        tick();
        chk("add_idle_write", rfWrite_o, 1'b0);
        chk("add_idle_done", done_o, 1'b0);

        // SUB r0 <= r2 - r1 = 0x06 - 0x07
        issue(3'd1, 3'd0, 3'd2, 3'd1, 8'h00);
        tick(); tick();
        chk("sub_data", rfData_o, 8'hFF);
        chk("sub_dest", rfDest_o, 3'd0);
`ifdef RFC_FLAGS_EN
        chk("sub_carry", carryFlag_o, 1'b1);
        chk("sub_zero", zeroFlag_o, 1'b0);
`endif
        tick();

        // Back-to-back: MOVI r5 <= 0xA5 then XOR r5 <= r5 ^ r5 held valid
        n0 = wr_log.size();
        issue(3'd6, 3'd5, 3'd0, 3'd0, 8'hA5);
        opcode_i = 3'd4; destReg_i = 3'd5; sourceReg1_i = 3'd5; sourceReg2_i = 3'd5;
        instValid_i = 1'b1;
        wait_acc();
        instValid_i = 1'b0;
        chk("b2b_spacing", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 4);
        tick(); tick(); tick();
        if (wr_log.size() >= n0 + 2) begin
            chk("b2b_wr0", wr_log[n0], {3'd5, 8'hA5});
            chk("b2b_wr1", wr_log[n0+1], {3'd5, 8'h00});
        end else begin
            n_vec++; n_bad++;
            $display("FAIL b2b_writes: got %0d writes expected 2", wr_log.size() - n0);
        end

        // NOP: done without write, result held at 0x00 from the XOR
        issue(3'd7, 3'd4, 3'd0, 3'd0, 8'h00);
        tick(); tick();
        chk("nop_done", done_o, 1'b1);
        chk("nop_write", rfWrite_o, 1'b0);
        chk("nop_result", result_o, 8'h00);
        tick();

        // SHL r6 <= 0x81 << 1
        issue(3'd6, 3'd1, 3'd0, 3'd0, 8'h81); tick(); tick(); tick();
        issue(3'd6, 3'd2, 3'd0, 3'd0, 8'h01); tick(); tick(); tick();
        issue(3'd5, 3'd6, 3'd1, 3'd2, 8'h00);
        tick(); tick();
        chk("shl_data", rfData_o, 8'h02);
        chk("shl_dest", rfDest_o, 3'd6);
`ifdef RFC_FLAGS_EN
        chk("shl_carry", carryFlag_o, 1'b1);
`endif
        tick();

        // Reset during WB of ADD r7 <= r1 + r2 aborts the write
        issue(3'd0, 3'd7, 3'd1, 3'd2, 8'h00);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_write", rfWrite_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_ready", instReady_o, 1'b1);
        chk("abort_rf7", rf[7], 8'hFF);
        chk("abort_result", result_o, 8'h00);

        // Randomized traffic with idle gaps and occasional resets
        repeat (150) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        repeat (5) tick();
        for (int i = 0; i < 8; i++) chk("final_rf", rf[i], m_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
